// File: rtl/mix_pkg.sv
// Shared constants for the MIX field unit: operation codes, FSM state encoding
// and field-spec decode helpers.
package mix_pkg;

  localparam logic [1:0] MODE_STORE   = 2'd0;
  localparam logic [1:0] MODE_LOAD    = 2'd1;
  localparam logic [1:0] MODE_LOADNEG = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CAPT = 2'b01;
  localparam logic [1:0] ST_EXEC = 2'b10;

  localparam int FIELD_L_LSB = 3;
  localparam int FIELD_R_LSB = 0;

  function automatic logic [2:0] field_l(input logic [5:0] f);
    return f[FIELD_L_LSB +: 3];
  endfunction

  function automatic logic [2:0] field_r(input logic [5:0] f);
    return f[FIELD_R_LSB +: 3];
  endfunction

endpackage

// File: rtl/field_unit_if.sv
// Request/response bundle between a requester and the field unit.
interface field_unit_if #(parameter int W = 31);

  logic          start;
  logic [1:0]    mode;
  logic [5:0]    field;
  logic [11:0]   addressin;
  logic [W-1:0]  data;
  logic [W-1:0]  in;
  logic          busy;
  logic          done;
  logic [W-1:0]  out;
  logic [11:0]   addressout;
  logic          err;

  modport master (
    output start, mode, field, addressin, data, in,
    input  busy, done, out, addressout, err
  );

  modport slave (
    input  start, mode, field, addressin, data, in,
    output busy, done, out, addressout, err
  );

endinterface

// File: rtl/field_mask.sv
// Byte mask for field (L:R) plus the shift that right-justifies byte R.
// Expects R already clipped to NBYTES; the sign bit is in the mask iff L=0.
module field_mask #(
    parameter int BYTE_W = 6,
    parameter int NBYTES = 5,
    parameter int W      = 1 + NBYTES * BYTE_W,
    parameter int SH_W   = $clog2(W)
) (
    input  logic [2:0]      l,
    input  logic [2:0]      r,
    output logic [W-1:0]    mask,
    output logic [SH_W-1:0] shift
);

    logic [2:0] l_min;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        l_min = (l == 3'd0) ? 3'd1 : l;
        mask  = '0;
        mask[W-1] = (l == 3'd0);
        for (int k = 1; k <= NBYTES; k++) begin
            if (k >= int'(l_min) && k <= int'(r))
                mask[(NBYTES-k)*BYTE_W +: BYTE_W] = '1;
        end
        shift = SH_W'((NBYTES - int'(r)) * BYTE_W);
    end

endmodule

// File: rtl/field_unit.sv
// MIX partial-field STORE / LOAD / LOADNEG unit, three-state request FSM.
// Build option FIELD_CHECK_EN: flag invalid fields on err instead of clipping them.
module field_unit
    import mix_pkg::*;
#(
    parameter int BYTE_W = 6,
    parameter int NBYTES = 5
) (
    input  logic          clk,
    input  logic          rst,
    field_unit_if.slave   bus
);

    localparam int W    = 1 + NBYTES * BYTE_W;
    localparam int SH_W = $clog2(W);

    logic [1:0]     state;
    logic [1:0]     cap_mode;
    logic [5:0]     cap_field;
    logic [11:0]    cap_addr;
    logic [W-1:0]   cap_data;
    logic [W-1:0]   cap_in;
    logic [2:0]     l_q;
    logic [2:0]     r_q;
    logic           done_q;
    logic [W-1:0]   out_q;
    logic [11:0]    addr_q;

    logic [2:0]     r_raw;
    logic [2:0]     r_clip;
    logic [W-1:0]   mask;
    logic [SH_W-1:0] shift;
    logic [W-1:0]   ins_aligned;
    logic [W-1:0]   store_val;
    logic [W-1:0]   load_val;
    logic [W-1:0]   result;

    assign r_raw  = field_r(cap_field);
    assign r_clip = (r_raw > 3'(NBYTES)) ? 3'(NBYTES) : r_raw;

    field_mask #(.BYTE_W(BYTE_W), .NBYTES(NBYTES), .W(W), .SH_W(SH_W)) u_mask (
        .l     (l_q),
        .r     (r_q),
        .mask  (mask),
        .shift (shift)
    );

    // Rightmost bytes of the register are slid up to end at byte R; sign travels separately.
    assign ins_aligned = {cap_in[W-1], cap_in[W-2:0] << shift};
    assign store_val   = (cap_data & ~mask) | (ins_aligned & mask);
    assign load_val    = {mask[W-1] & cap_data[W-1], (cap_data[W-2:0] & mask[W-2:0]) >> shift};

`ifdef FIELD_CHECK_EN
    logic inv_q;
    logic err_q;

    always_comb begin
        result = load_val;
        if (cap_mode == MODE_STORE)
            result = inv_q ? cap_data : store_val;
        else if (inv_q)
            result = '0;
        else if (cap_mode == MODE_LOADNEG)
            result = {~load_val[W-1], load_val[W-2:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (state == ST_CAPT)
                inv_q <= (field_l(cap_field) > r_raw) || (r_raw > 3'(NBYTES));
            if (state == ST_EXEC)
                err_q <= inv_q;
        end
    end

    assign bus.err = err_q;
`else
    always_comb begin
        result = load_val;
        if (cap_mode == MODE_STORE)
            result = store_val;
        else if (cap_mode == MODE_LOADNEG)
            result = {~load_val[W-1], load_val[W-2:0]};
    end

    assign bus.err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only; the captured operand registers are reset too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cap_mode  <= '0;
            cap_field <= '0;
            cap_addr  <= '0;
            cap_data  <= '0;
            cap_in    <= '0;
            l_q       <= '0;
            r_q       <= '0;
            done_q    <= 1'b0;
            out_q     <= '0;
            addr_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cap_mode  <= bus.mode;
                        cap_field <= bus.field;
                        cap_addr  <= bus.addressin;
                        cap_data  <= bus.data;
                        cap_in    <= bus.in;
                        state     <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    l_q   <= field_l(cap_field);
                    r_q   <= r_clip;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    out_q  <= result;
                    addr_q <= cap_addr;
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy       = (state == ST_CAPT) || (state == ST_EXEC);
    assign bus.done       = done_q;
    assign bus.out        = out_q;
    assign bus.addressout = addr_q;

endmodule

// File: tb/tb_field_unit.sv
// Directed self-checking bench for field_unit (BYTE_W=6, NBYTES=5, W=31).
module tb_field_unit;
    import mix_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    field_unit_if #(.W(31)) bus ();

    field_unit #(.BYTE_W(6), .NBYTES(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] m, input logic [5:0] f,
                         input logic [11:0] a, input logic [30:0] d, input logic [30:0] i);
        int n;
        @(negedge clk);
        bus.mode = m; bus.field = f; bus.addressin = a; bus.data = d; bus.in = i;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd2);
    endtask

    initial begin
        int dcount;
        logic [11:0] addr_seen;
        logic [30:0] out_seen;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.mode = '0; bus.field = '0; bus.addressin = '0;
        bus.data = '0; bus.in = '0;
        #2;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset out", 32'(bus.out), 32'd0);
        check("reset addr", 32'(bus.addressout), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("store 1:3", MODE_STORE, 6'd11, 12'h0A5, 31'h7FFFFFFF, 31'h0);
        check("store 1:3 out", 32'(bus.out), 32'h40000FFF);
        check("store 1:3 err", 32'(bus.err), 32'd0);
        check("store 1:3 addr", 32'(bus.addressout), 32'h0A5);
        @(negedge clk);
        check("done one-shot", 32'(bus.done), 32'd0);
        check("out holds", 32'(bus.out), 32'h40000FFF);

        do_op("load 4:5", MODE_LOAD, 6'd37, 12'h001, 31'h40000FFF, 31'h7FFFFFFF);
        check("load 4:5 out", 32'(bus.out), 32'h00000FFF);
        do_op("load 0:0", MODE_LOAD, 6'd0, 12'h002, 31'h40000FFF, 31'h0);
        check("load 0:0 out", 32'(bus.out), 32'h40000000);
        do_op("loadneg 0:5", MODE_LOADNEG, 6'd5, 12'h003, 31'h00000001, 31'h0);
        check("loadneg 0:5 out", 32'(bus.out), 32'h40000001);
        do_op("load 2:2", MODE_LOAD, 6'd18, 12'h004, 31'h12345678, 31'h0);
        check("load 2:2 out", 32'(bus.out), 32'h0000000D);
        do_op("store 2:3", MODE_STORE, 6'd19, 12'h005, 31'h0, 31'h00000ABC);
        check("store 2:3 out", 32'(bus.out), 32'h00ABC000);
        do_op("store 0:0", MODE_STORE, 6'd0, 12'h006, 31'h12345678, 31'h40000000);
        check("store 0:0 out", 32'(bus.out), 32'h52345678);
        do_op("mode3 4:5", 2'd3, 6'd37, 12'h007, 31'h40000FFF, 31'h0);
        check("mode3 out", 32'(bus.out), 32'h00000FFF);

`ifdef FIELD_CHECK_EN
        do_op("store 0:6", MODE_STORE, 6'd6, 12'h008, 31'h12345678, 31'h00000ABC);
        check("store 0:6 err", 32'(bus.err), 32'd1);
        check("store 0:6 out", 32'(bus.out), 32'h12345678);
        do_op("load 3:2", MODE_LOAD, 6'd26, 12'h009, 31'h12345678, 31'h0);
        check("load 3:2 err", 32'(bus.err), 32'd1);
        check("load 3:2 out", 32'(bus.out), 32'h0);
`else
        do_op("store 0:6", MODE_STORE, 6'd6, 12'h008, 31'h12345678, 31'h00000ABC);
        check("store 0:6 err", 32'(bus.err), 32'd0);
        check("store 0:6 out", 32'(bus.out), 32'h00000ABC);
        do_op("load 3:2", MODE_LOAD, 6'd26, 12'h009, 31'h12345678, 31'h0);
        check("load 3:2 err", 32'(bus.err), 32'd0);
        check("load 3:2 out", 32'(bus.out), 32'h0);
`endif

        // Second start one cycle later must be ignored.
        @(negedge clk);
        bus.mode = MODE_LOAD; bus.field = 6'd37; bus.addressin = 12'h111;
        bus.data = 31'h40000FFF; bus.start = 1'b1;
        @(negedge clk);
        bus.addressin = 12'h222; bus.data = 31'h0;
        @(negedge clk);
        bus.start = 1'b0;
        dcount = 0; addr_seen = '0; out_seen = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dcount++;
                addr_seen = bus.addressout;
                out_seen  = bus.out;
            end
        end
        check("ignore dones", 32'(dcount), 32'd1);
        check("ignore addr", 32'(addr_seen), 32'h111);
        check("ignore out", 32'(out_seen), 32'h00000FFF);

        // Reset while in EXEC aborts the request.
        @(negedge clk);
        bus.mode = MODE_LOAD; bus.field = 6'd37; bus.addressin = 12'h333;
        bus.data = 31'h40000FFF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort out", 32'(bus.out), 32'h0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort addr", 32'(bus.addressout), 32'h0);
        #1 rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        check("abort no done", 32'(dcount), 32'd0);
        check("abort busy idle", 32'(bus.busy), 32'd0);

        do_op("after abort", MODE_LOADNEG, 6'd37, 12'h444, 31'h40000FFF, 31'h0);
        check("after abort out", 32'(bus.out), 32'h40000FFF);
        check("after abort addr", 32'(bus.addressout), 32'h444);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/field_unit.md
FIELD_UNIT -- requirements
Module: field_unit

Interface
REQ-001 Parameter BYTE_W, default 6, bits per MIX byte.
REQ-002 Parameter NBYTES, default 5, magnitude bytes per word, legal range 1..7; word width W = 1 + NBYTES*BYTE_W, sign at bit W-1.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request pulse.
REQ-006 mode  input  2  operation: 0 STORE, 1 LOAD, 2 LOADNEG, 3 reserved (treated as LOAD).
REQ-007 field  input  6  field spec F = 8L+R, L = field[5:3], R = field[2:0].
REQ-008 addressin  input  12  memory address accompanying request.
REQ-009 data  input  W  memory word: STORE target, or LOAD/LOADNEG source.
REQ-010 in  input  W  register value: STORE source, ignored otherwise.
REQ-011 busy  output  1  request in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 out  output  W  registered result.
REQ-014 addressout  output  12  addressin captured with the request.
REQ-015 err  output  1  invalid field flag, valid with done.

Function
REQ-016 Bytes numbered 1..NBYTES, MSB to LSB; byte NBYTES least significant; position 0 is the sign.
REQ-017 start sampled at edge N while idle: field, mode, addressin, data and in captured; busy=1 from N through N+1; done=1 and out/addressout/err valid for the cycle after edge N+2.
REQ-018 FSM: IDLE -(start)-> CAPT -> EXEC -> IDLE; done pulses on entry to IDLE from EXEC; busy=1 in CAPT and EXEC.
REQ-019 start asserted while busy=1 is ignored; no queuing, captured operands unchanged.
REQ-020 out, addressout and err hold their values until the next completion.
REQ-021 STORE: bytes max(L,1)..R of data replaced by the rightmost R-max(L,1)+1 bytes of in; sign replaced by in sign iff L=0; all other bits from data.
REQ-022 LOAD: bytes max(L,1)..R of data right-justified into out, upper bytes zero; out sign = data sign if L=0, else 0.
REQ-023 LOADNEG: as LOAD with out sign inverted.
REQ-024 Field (0:0): STORE sign only; LOAD yields zero magnitude with data sign.
REQ-025 Invalid field: L>R or R>NBYTES.
REQ-026 Same-cycle start and rst: rst wins, request discarded.

Reset
REQ-027 rst asserted: FSM to IDLE, busy=0, done=0, err=0, out=0, addressout=0, captured registers 0, all immediately without clock.
REQ-028 rst mid-operation aborts the request; no done pulse follows.

Configuration
REQ-029 Macro FIELD_CHECK_EN defined: invalid field gives err=1 with done, out = captured data for STORE, out = 0 for LOAD/LOADNEG.
REQ-030 FIELD_CHECK_EN undefined: err tied 0; R clipped to NBYTES; L>R with L>0 selects no bytes (STORE returns data, LOAD returns 0); L>R with L=0 affects sign only.

Structure
REQ-031 Shared package mix_pkg holds mode constants (MODE_STORE, MODE_LOAD, MODE_LOADNEG), FSM state encoding and field-decode helper constants.
REQ-032 One sub-module field_mask: combinational, from L, R, NBYTES, BYTE_W produces W-bit byte mask and right-justify shift count; instantiated once in EXEC datapath.

Verification (BYTE_W=6, NBYTES=5, W=31)
REQ-033 STORE F=11 (1:3), data=31'h7FFFFFFF, in=0 -> out=31'h40000FFF, done at N+2 edge, err=0.
REQ-034 LOAD F=37 (4:5), data=31'h40000FFF -> out=31'h00000FFF; LOAD F=0, same data -> out=31'h40000000.
REQ-035 LOADNEG F=5 (0:5), data=31'h00000001 -> out=31'h40000001.
REQ-036 FIELD_CHECK_EN defined, STORE F=6 (0:6), data=31'h12345678 -> err=1, out=31'h12345678; F=26 (3:2) LOAD -> err=1, out=0.
REQ-037 start at N and N+1 with different addressin -> exactly one done, addressout = value from N.
REQ-038 rst pulsed in EXEC -> no done, out=0, busy=0; next start completes normally.
